// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the shift-instruction control path: sequencer states,
// shift opcodes, IR field positions and small decode helpers.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6
  } state_t;

  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;

  localparam logic [3:0] MEM_TIMEOUT = 4'd8;

  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  function automatic logic is_shift_opc(input logic [4:0] opc);
    logic hit;
    case (opc)
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: hit = 1'b1;
      default:                                 hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ir_field_decoder.sv
// Splits the IR word into opcode and one-hot register selects, and flags
// whether the opcode belongs to the shift/rotate group.
module ir_field_decoder
  import cpu_defs_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_opc,
  output logic [15:0] o_ra_oh,
  output logic [15:0] o_rb_oh,
  output logic [15:0] o_rc_oh,
  output logic        o_is_shift
);

  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_unused_low;

  assign o_opc = i_ir[OPC_LSB +: 5];
  assign w_ra  = i_ir[RA_LSB +: 4];
  assign w_rb  = i_ir[RB_LSB +: 4];
  assign w_rc  = i_ir[RC_LSB +: 4];

  // Immediate/low bits carry nothing for register-register shifts.
  assign w_unused_low = ^i_ir[14:0];

  assign o_ra_oh    = onehot16(w_ra);
  assign o_rb_oh    = onehot16(w_rb);
  assign o_rc_oh    = onehot16(w_rc);
  assign o_is_shift = is_shift_opc(o_opc);

endmodule

// File: rtl/shift_control_unit.sv
// Fetch/execute sequencer for register-register shift and rotate instructions;
// drives the datapath control strobes from the current state and decoded IR.
module shift_control_unit
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir_data,
  output logic        pc_out,
  output logic        mar_in,
  output logic        pc_increment,
  output logic        mdr_read,
  output logic        mdr_enable,
  output logic        mdr_out,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        zlo_enable,
  output logic        zlo_out,
  output logic [15:0] r_enable,
  output logic [15:0] r_out,
  output logic [4:0]  op_code,
  output logic        done,
  output logic        illegal
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_next_wait;

  logic [4:0]  w_opc;
  logic [15:0] w_ra_oh;
  logic [15:0] w_rb_oh;
  logic [15:0] w_rc_oh;
  logic        w_is_shift;

  ir_field_decoder u_dec (
    .i_ir       (ir_data),
    .o_opc      (w_opc),
    .o_ra_oh    (w_ra_oh),
    .o_rb_oh    (w_rb_oh),
    .o_rc_oh    (w_rc_oh),
    .o_is_shift (w_is_shift)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  // The wait counter is only meaningful in T1; every other state clears it.
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = 4'd0;
    pc_out       = 1'b0;
    mar_in       = 1'b0;
    pc_increment = 1'b0;
    mdr_read     = 1'b0;
    mdr_enable   = 1'b0;
    mdr_out      = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    zlo_enable   = 1'b0;
    zlo_out      = 1'b0;
    r_enable     = 16'd0;
    r_out        = 16'd0;
    op_code      = 5'd0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_next_state = ST_T0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_T0: begin
        pc_out       = 1'b1;
        mar_in       = 1'b1;
        pc_increment = 1'b1;
        w_next_state = ST_T1;
      end
      ST_T1: begin
        mdr_read   = 1'b1;
        mdr_enable = mem_rdy;
        if (mem_rdy) begin
          w_next_state = ST_T2;
        end else if (r_wait_cnt == (MEM_TIMEOUT - 4'd1)) begin
          illegal      = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_wait  = r_wait_cnt + 4'd1;
          w_next_state = ST_T1;
        end
      end
      ST_T2: begin
        mdr_out      = 1'b1;
        ir_enable    = 1'b1;
        w_next_state = ST_T3;
      end
      ST_T3: begin
        if (w_is_shift) begin
          r_out        = w_rb_oh;
          y_enable     = 1'b1;
          w_next_state = ST_T4;
        end else begin
          illegal      = 1'b1;
          w_next_state = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T4: begin
        r_out        = w_rc_oh;
        op_code      = w_opc;
        zlo_enable   = 1'b1;
        w_next_state = ST_T5;
      end
      ST_T5: begin
        zlo_out      = 1'b1;
        r_enable     = w_ra_oh;
        op_code      = w_opc;
        done         = 1'b1;
        w_next_state = run ? ST_T0 : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_control_unit.sv
// Scoreboard bench: each driven cycle pushes the expected control vector,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_shift_control_unit;

  typedef struct packed {
    logic        pc_out;
    logic        mar_in;
    logic        pc_inc;
    logic        mdr_read;
    logic        mdr_en;
    logic        mdr_out;
    logic        ir_en;
    logic        y_en;
    logic        zlo_en;
    logic        zlo_out;
    logic [15:0] ren;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        done;
    logic        ill;
  } ov_t;

  logic        clk;
  logic        clr;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir_data;
  logic        pc_out, mar_in, pc_increment, mdr_read, mdr_enable, mdr_out;
  logic        ir_enable, y_enable, zlo_enable, zlo_out, done, illegal;
  logic [15:0] r_enable, r_out;
  logic [4:0]  op_code;

  ov_t   obs;
  ov_t   exp_q[$];
  string tag_q[$];
  int    total;
  int    bad;

  shift_control_unit dut (
    .clk          (clk),
    .clr          (clr),
    .run          (run),
    .mem_rdy      (mem_rdy),
    .ir_data      (ir_data),
    .pc_out       (pc_out),
    .mar_in       (mar_in),
    .pc_increment (pc_increment),
    .mdr_read     (mdr_read),
    .mdr_enable   (mdr_enable),
    .mdr_out      (mdr_out),
    .ir_enable    (ir_enable),
    .y_enable     (y_enable),
    .zlo_enable   (zlo_enable),
    .zlo_out      (zlo_out),
    .r_enable     (r_enable),
    .r_out        (r_out),
    .op_code      (op_code),
    .done         (done),
    .illegal      (illegal)
  );

  assign obs = '{pc_out, mar_in, pc_increment, mdr_read, mdr_enable, mdr_out,
                 ir_enable, y_enable, zlo_enable, zlo_out, r_enable, r_out,
                 op_code, done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ov_t   e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 64'(obs), 64'(e));
    end
  end

  task automatic drv(input logic c, input logic r, input logic rdy,
                     input logic [31:0] ir, input ov_t e, input string t);
    @(posedge clk);
    #1;
    clr     = c;
    run     = r;
    mem_rdy = rdy;
    ir_data = ir;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'd0};
  endfunction

  function automatic logic tb_is_shift(input logic [4:0] opc);
    return (opc == 5'b00101) || (opc == 5'b00110) || (opc == 5'b00111) ||
           (opc == 5'b01000) || (opc == 5'b01001);
  endfunction

  // One full instruction starting in T0; mid_run is driven T0..T4, run_after at the exit.
  task automatic run_instr(input logic [31:0] ir, input int waits, input logic mid_run,
                           input logic run_after, input string nm);
    ov_t        e;
    logic [4:0] opc;
    opc = ir[31:27];
    e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1; e.pc_inc = 1'b1;
    drv(1'b1, mid_run, 1'b0, ir, e, {nm, "_T0"});
    for (int w = 0; w < waits; w++) begin
      e = '0; e.mdr_read = 1'b1;
      drv(1'b1, mid_run, 1'b0, ir, e, $sformatf("%s_T1w%0d", nm, w));
    end
    e = '0; e.mdr_read = 1'b1; e.mdr_en = 1'b1;
    drv(1'b1, mid_run, 1'b1, ir, e, {nm, "_T1"});
    e = '0; e.mdr_out = 1'b1; e.ir_en = 1'b1;
    drv(1'b1, mid_run, 1'b0, ir, e, {nm, "_T2"});
    if (!tb_is_shift(opc)) begin
      e = '0; e.ill = 1'b1;
      drv(1'b1, run_after, 1'b0, ir, e, {nm, "_T3ill"});
    end else begin
      e = '0; e.rout = 16'd1 << ir[22:19]; e.y_en = 1'b1;
      drv(1'b1, mid_run, 1'b0, ir, e, {nm, "_T3"});
      e = '0; e.rout = 16'd1 << ir[18:15]; e.op = opc; e.zlo_en = 1'b1;
      drv(1'b1, mid_run, 1'b0, ir, e, {nm, "_T4"});
      e = '0; e.zlo_out = 1'b1; e.ren = 16'd1 << ir[26:23]; e.op = opc; e.done = 1'b1;
      drv(1'b1, run_after, 1'b0, ir, e, {nm, "_T5"});
    end
  endtask

  initial begin
    ov_t         z;
    ov_t         e;
    logic [31:0] ir;
    logic [4:0]  shops [5];
    total   = 0;
    bad     = 0;
    z       = '0;
    shops   = '{5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001};
    clr     = 1'b0;
    run     = 1'b1;
    mem_rdy = 1'b0;
    ir_data = 32'd0;
    repeat (2) @(posedge clk);
    drv(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, z, "rst_hold");
    drv(1'b1, 1'b1, 1'b0, 32'd0, z, "rst_idle");

    run_instr(32'h2998_0000, 0, 1'b1, 1'b1, "shr330");
    run_instr(mk_ir(5'b00111, 4'd5, 4'd9, 4'd15), 3, 1'b1, 1'b1, "shl_wait3");
    run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1'b1, 1'b1, "add_ill");
    run_instr(mk_ir(5'b01000, 4'd15, 4'd15, 4'd15), 1, 1'b0, 1'b1, "ror_rundrop");
    for (int k = 0; k < 5; k++) begin
      ir = mk_ir(shops[k], 4'($urandom_range(15)), 4'($urandom_range(15)),
                 4'($urandom_range(15))) | 32'($urandom_range(32767));
      run_instr(ir, int'($urandom_range(2)), 1'b1, 1'b1, $sformatf("rnd%0d", k));
    end

    // memory never answers: abort on the eighth T1 cycle
    e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1; e.pc_inc = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 32'd0, e, "tmo_T0");
    for (int w = 0; w < 7; w++) begin
      e = '0; e.mdr_read = 1'b1;
      drv(1'b1, 1'b1, 1'b0, 32'd0, e, $sformatf("tmo_T1w%0d", w));
    end
    e = '0; e.mdr_read = 1'b1; e.ill = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 32'd0, e, "tmo_abort");
    drv(1'b1, 1'b0, 1'b1, 32'd0, z, "tmo_idle0");
    drv(1'b1, 1'b1, 1'b0, 32'd0, z, "tmo_idle1");

    // clear while in T4
    ir = mk_ir(5'b00110, 4'd7, 4'd2, 4'd11);
    e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1; e.pc_inc = 1'b1;
    drv(1'b1, 1'b1, 1'b0, ir, e, "clr_T0");
    e = '0; e.mdr_read = 1'b1; e.mdr_en = 1'b1;
    drv(1'b1, 1'b1, 1'b1, ir, e, "clr_T1");
    e = '0; e.mdr_out = 1'b1; e.ir_en = 1'b1;
    drv(1'b1, 1'b1, 1'b0, ir, e, "clr_T2");
    e = '0; e.rout = 16'h0004; e.y_en = 1'b1;
    drv(1'b1, 1'b1, 1'b0, ir, e, "clr_T3");
    e = '0; e.rout = 16'h0800; e.op = 5'b00110; e.zlo_en = 1'b1;
    drv(1'b0, 1'b1, 1'b0, ir, e, "clr_T4");
    drv(1'b1, 1'b0, 1'b0, ir, z, "clr_after0");
    drv(1'b1, 1'b1, 1'b1, ir, z, "clr_after1");

    run_instr(mk_ir(5'b01001, 4'd0, 4'd8, 4'd0), 0, 1'b1, 1'b0, "rol_last");
    drv(1'b1, 1'b0, 1'b1, 32'd0, z, "end_idle");

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
